// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared types, constants and hex helpers for the command frame parser.
//   state_t      - parser state encoding
//   ASCII_*      - character bounds used by the hex decoder
//   MAX_NIBBLES  - largest nibble count the two-character length field can express
//   hex_valid()  - 1 when the byte is a hex digit ('0'-'9', 'A'-'F', 'a'-'f')
//   hex_value()  - 4-bit value of a hex digit (0 for non-hex bytes)
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_CMD    = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LEN_LO = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_HOLD   = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  localparam int unsigned LEN_FIELD_W = 8;
  localparam int unsigned MAX_NIBBLES = 255;

  function automatic logic hex_valid(input logic [7:0] code);
    return ((code >= ASCII_0)  && (code <= ASCII_9))  ||
           ((code >= ASCII_UA) && (code <= ASCII_UF)) ||
           ((code >= ASCII_LA) && (code <= ASCII_LF));
  endfunction

  function automatic logic [3:0] hex_value(input logic [7:0] code);
    logic [3:0] val;
    val = 4'h0;
    if ((code >= ASCII_0) && (code <= ASCII_9)) begin
      val = 4'(code - ASCII_0);
    end else if ((code >= ASCII_UA) && (code <= ASCII_UF)) begin
      val = 4'(code - ASCII_UA + 8'd10);
    end else if ((code >= ASCII_LA) && (code <= ASCII_LF)) begin
      val = 4'(code - ASCII_LA + 8'd10);
    end
    return val;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_hex_decode.sv
// hex_ascii_decode: combinational ASCII hex character decoder.
//   code     in  8  ASCII byte
//   value_c  out 4  decoded nibble (0 when not a hex digit)
//   valid_c  out 1  byte is '0'-'9', 'A'-'F' or 'a'-'f'
module hex_ascii_decode
  import cmd_frame_pkg::*;
(
  input  logic [7:0] code,
  output logic [3:0] value_c,
  output logic       valid_c
);

  always_comb begin
    value_c = hex_value(code);
    valid_c = hex_valid(code);
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: byte-stream frame parser between the UART receiver and the hashing core.
// Frame: sync bytes, 1 hex command char, 2 hex length chars (N nibbles), N hex payload chars,
// plus one XOR checksum char when CMD_FRAME_PARSER_CSUM_EN is defined.
//   clk             in   system clock
//   rst             in   asynchronous active-high reset
//   byte_available  in   receiver level; a rising edge marks a new byte
//   byte_in         in   ASCII byte, stable when byte_available rises
//   data_request    in   core acknowledge; consumes the held frame
//   command         out  decoded command nibble
//   data_count      out  payload length in nibbles
//   buffer          out  payload, right-justified, zero-extended
//   ready           out  a frame is held and outputs are valid
//   busy            out  parser is mid-frame (not SYNC or HOLD)
//   err_count       out  saturating count of rejected frames
// Optional feature macro: CMD_FRAME_PARSER_CSUM_EN (trailing checksum character).
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD  = 32'h4C454146,
  parameter int unsigned SYNC_BYTES = 4,
  parameter int unsigned PAYLOAD_W  = 256,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 byte_available,
  input  logic [7:0]           byte_in,
  input  logic                 data_request,
  output logic [3:0]           command,
  output logic [LEN_W-1:0]     data_count,
  output logic [PAYLOAD_W-1:0] buffer,
  output logic                 ready,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam logic [2:0]             SYNC_LAST_IDX = 3'(SYNC_BYTES - 1);
  localparam logic [LEN_FIELD_W-1:0] MAX_N         = LEN_FIELD_W'(PAYLOAD_W / 4);
  localparam logic [7:0]             SYNC_BYTE0    = SYNC_WORD[31:24];

  // Registered state and working storage
  state_t                 state;
  logic [2:0]             sync_idx;
  logic                   prev;
  logic [3:0]             cmd_work;
  logic [LEN_FIELD_W-1:0] len_work;
  logic [LEN_FIELD_W-1:0] cnt;
  logic [PAYLOAD_W-1:0]   shreg;

  // Next-state values
  state_t                 state_d;
  logic [2:0]             sync_idx_d;
  logic [3:0]             cmd_work_d;
  logic [LEN_FIELD_W-1:0] len_work_d;
  logic [LEN_FIELD_W-1:0] cnt_d;
  logic [PAYLOAD_W-1:0]   shreg_d;
  logic [3:0]             command_d;
  logic [LEN_W-1:0]       data_count_d;
  logic [PAYLOAD_W-1:0]   buffer_d;
  logic [7:0]             err_count_d;
  logic                   ready_d;
  logic                   busy_d;

  logic                   strobe_c;
  logic [3:0]             nib_c;
  logic                   nib_ok_c;
  logic [7:0]             sync_cur_c;
  logic                   err_c;
  logic                   hold_entry_c;

  hex_ascii_decode u_hex (
    .code    (byte_in),
    .value_c (nib_c),
    .valid_c (nib_ok_c)
  );

  // prev resets high so a level already high at reset release is not a new byte
  assign strobe_c = byte_available & ~prev;

  // Sync byte expected at the current match index, MSB-first from SYNC_WORD
  always_comb begin
    case (sync_idx)
      3'd0:    sync_cur_c = SYNC_WORD[31:24];
      3'd1:    sync_cur_c = SYNC_WORD[23:16];
      3'd2:    sync_cur_c = SYNC_WORD[15:8];
      default: sync_cur_c = SYNC_WORD[7:0];
    endcase
  end

`ifdef CMD_FRAME_PARSER_CSUM_EN
  // Running XOR of every decoded nibble of the frame, seeded by the command char
  logic [3:0] csum;
  logic [3:0] csum_d;

  always_comb begin
    csum_d = csum;
    if (strobe_c && nib_ok_c) begin
      case (state)
        ST_CMD:                       csum_d = nib_c;
        ST_LEN_HI, ST_LEN_LO, ST_DATA: csum_d = csum ^ nib_c;
        default:                      csum_d = csum;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 4'h0;
    end else begin
      csum <= csum_d;
    end
  end
`endif

  // Next-state and output computation
  always_comb begin
    state_d      = state;
    sync_idx_d   = sync_idx;
    cmd_work_d   = cmd_work;
    len_work_d   = len_work;
    cnt_d        = cnt;
    shreg_d      = shreg;
    command_d    = command;
    data_count_d = data_count;
    buffer_d     = buffer;
    err_count_d  = err_count;
    err_c        = 1'b0;
    hold_entry_c = 1'b0;

    case (state)
      ST_SYNC: begin
        if (strobe_c) begin
          if (byte_in == sync_cur_c) begin
            if (sync_idx == SYNC_LAST_IDX) begin
              state_d    = ST_CMD;
              sync_idx_d = 3'd0;
              shreg_d    = '0;
            end else begin
              sync_idx_d = sync_idx + 3'd1;
            end
          end else begin
            // A mismatching byte may itself start a new sync sequence
            sync_idx_d = (byte_in == SYNC_BYTE0) ? 3'd1 : 3'd0;
          end
        end
      end

      ST_CMD: begin
        if (strobe_c) begin
          if (nib_ok_c) begin
            cmd_work_d = nib_c;
            state_d    = ST_LEN_HI;
          end else begin
            err_c = 1'b1;
          end
        end
      end

      ST_LEN_HI: begin
        if (strobe_c) begin
          if (nib_ok_c) begin
            len_work_d = {nib_c, 4'h0};
            state_d    = ST_LEN_LO;
          end else begin
            err_c = 1'b1;
          end
        end
      end

      ST_LEN_LO: begin
        if (strobe_c) begin
          if (nib_ok_c) begin
            len_work_d = {len_work[7:4], nib_c};
            cnt_d      = '0;
            if ((len_work_d == '0) || (len_work_d > MAX_N)) begin
              err_c = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            err_c = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (strobe_c) begin
          if (nib_ok_c) begin
            shreg_d = (shreg << 4) | PAYLOAD_W'(nib_c);
            cnt_d   = cnt + LEN_FIELD_W'(1);
            if (cnt_d == len_work) begin
`ifdef CMD_FRAME_PARSER_CSUM_EN
              state_d = ST_CSUM;
`else
              hold_entry_c = 1'b1;
`endif
            end
          end else begin
            err_c = 1'b1;
          end
        end
      end

`ifdef CMD_FRAME_PARSER_CSUM_EN
      ST_CSUM: begin
        if (strobe_c) begin
          if (nib_ok_c && (nib_c == csum)) begin
            hold_entry_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      end
`endif

      ST_HOLD: begin
        // Strobes here are dropped; only the core acknowledge leaves HOLD
        if (data_request && ready) begin
          state_d    = ST_SYNC;
          sync_idx_d = 3'd0;
        end
      end

      default: begin
        state_d    = ST_SYNC;
        sync_idx_d = 3'd0;
      end
    endcase

    if (hold_entry_c) begin
      state_d      = ST_HOLD;
      command_d    = cmd_work_d;
      data_count_d = LEN_W'(len_work_d);
      buffer_d     = shreg_d;
    end

    // The offending byte is consumed here and never reused as a sync byte
    if (err_c) begin
      state_d     = ST_SYNC;
      sync_idx_d  = 3'd0;
      err_count_d = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    ready_d = (state_d == ST_HOLD);
    busy_d  = (state_d != ST_SYNC) && (state_d != ST_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      sync_idx   <= 3'd0;
      prev       <= 1'b1;
      cmd_work   <= 4'h0;
      len_work   <= '0;
      cnt        <= '0;
      shreg      <= '0;
      command    <= 4'h0;
      data_count <= '0;
      buffer     <= '0;
      err_count  <= 8'h00;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sync_idx   <= sync_idx_d;
      prev       <= byte_available;
      cmd_work   <= cmd_work_d;
      len_work   <= len_work_d;
      cnt        <= cnt_d;
      shreg      <= shreg_d;
      command    <= command_d;
      data_count <= data_count_d;
      buffer     <= buffer_d;
      err_count  <= err_count_d;
      ready      <= ready_d;
      busy       <= busy_d;
    end
  end

endmodule
